// File: rtl/uart_frame_decoder.sv
// UART frame decoder: parses SYNC/CMD/LEN/payload/XOR-checksum frames and streams little-endian payload words.
// Optional frame statistics counters are enabled by defining UART_FRAME_STATS_EN.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         WORD_BYTES     = 4,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [7:0]              data_byte_in,
  input  logic                    new_data_in,
  output logic [8*WORD_BYTES-1:0] word_out,
  output logic                    word_valid_out,
  input  logic                    word_ready_in,
  output logic                    word_last_out,
  output logic [7:0]              cmd_out,
  output logic                    frame_start_out,
  output logic                    frame_ok_out,
  output logic                    frame_err_out,
  output logic [1:0]              err_code_out
`ifdef UART_FRAME_STATS_EN
  ,
  output logic [15:0]             frames_ok_count_out,
  output logic [15:0]             frames_err_count_out
`endif
);

  localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [7:0]              r_chk;
  logic [7:0]              r_len;
  logic [7:0]              r_wordCnt;
  logic [LW-1:0]           r_byteIdx;
  logic [8*WORD_BYTES-1:0] r_asm;
  logic [TW-1:0]           r_timeoutCnt;

  logic                    w_timeout;
  logic                    w_laneDone;
  logic                    w_outFree;
  logic                    w_lastWord;
  logic [8*WORD_BYTES-1:0] w_fullWord;
  logic                    w_startPulse;
  logic                    w_okPulse;
  logic                    w_errPulse;
  logic [1:0]              w_errCode;
  logic                    w_loadWord;

  // A byte strobe in the same cycle always wins over the timeout.
  assign w_timeout  = (r_state != S_HUNT) && !new_data_in &&
                      (r_timeoutCnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_laneDone = new_data_in && (r_state == S_PAYLOAD) && (r_byteIdx == LAST_LANE);
  assign w_outFree  = !word_valid_out || word_ready_in;
  assign w_lastWord = (r_wordCnt == (r_len - 8'd1));

  always_comb begin
    w_fullWord = r_asm;
    w_fullWord[8*(WORD_BYTES-1) +: 8] = data_byte_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= S_HUNT;
    else           r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (w_timeout) begin
      w_nextState = S_HUNT;
    end else if (new_data_in) begin
      case (r_state)
        S_HUNT:    if (data_byte_in == SYNC_BYTE) w_nextState = S_CMD;
        S_CMD:     w_nextState = S_LEN;
        S_LEN:     w_nextState = (data_byte_in == 8'd0) ? S_CHECK : S_PAYLOAD;
        S_PAYLOAD: begin
          if (w_laneDone) begin
            if (!w_outFree)      w_nextState = S_HUNT;
            else if (w_lastWord) w_nextState = S_CHECK;
          end
        end
        S_CHECK:   w_nextState = S_HUNT;
        default:   w_nextState = S_HUNT;
      endcase
    end
  end

  always_comb begin
    w_startPulse = 1'b0;
    w_okPulse    = 1'b0;
    w_errPulse   = 1'b0;
    w_errCode    = 2'd0;
    w_loadWord   = 1'b0;
    if (w_timeout) begin
      w_errPulse = 1'b1;
      w_errCode  = 2'd3;
    end else if (new_data_in) begin
      case (r_state)
        S_LEN: w_startPulse = 1'b1;
        S_PAYLOAD: begin
          if (w_laneDone) begin
            if (w_outFree) begin
              w_loadWord = 1'b1;
            end else begin
              w_errPulse = 1'b1;
              w_errCode  = 2'd2;
            end
          end
        end
        S_CHECK: begin
          if (data_byte_in == r_chk) begin
            w_okPulse = 1'b1;
          end else begin
            w_errPulse = 1'b1;
            w_errCode  = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      word_out        <= '0;
      word_valid_out  <= 1'b0;
      word_last_out   <= 1'b0;
      cmd_out         <= 8'd0;
      frame_start_out <= 1'b0;
      frame_ok_out    <= 1'b0;
      frame_err_out   <= 1'b0;
      err_code_out    <= 2'd0;
      r_chk           <= 8'd0;
      r_len           <= 8'd0;
      r_wordCnt       <= 8'd0;
      r_byteIdx       <= '0;
      r_asm           <= '0;
      r_timeoutCnt    <= '0;
    end else begin
      frame_start_out <= w_startPulse;
      frame_ok_out    <= w_okPulse;
      frame_err_out   <= w_errPulse;
      err_code_out    <= w_errCode;

      if (new_data_in || (r_state == S_HUNT)) r_timeoutCnt <= '0;
      else                                    r_timeoutCnt <= r_timeoutCnt + TW'(1);

      // A pending word is never retracted by a frame error; only the consumer drains it.
      if (w_loadWord) begin
        word_out       <= w_fullWord;
        word_valid_out <= 1'b1;
        word_last_out  <= w_lastWord;
      end else if (word_valid_out && word_ready_in) begin
        word_valid_out <= 1'b0;
        word_last_out  <= 1'b0;
      end

      if (new_data_in && !w_timeout) begin
        case (r_state)
          S_CMD: begin
            cmd_out <= data_byte_in;
            r_chk   <= data_byte_in;
          end
          S_LEN: begin
            r_chk     <= r_chk ^ data_byte_in;
            r_len     <= data_byte_in;
            r_wordCnt <= 8'd0;
            r_byteIdx <= '0;
          end
          S_PAYLOAD: begin
            r_chk <= r_chk ^ data_byte_in;
            for (int i = 0; i < WORD_BYTES; i++) begin
              if (r_byteIdx == LW'(i)) r_asm[8*i +: 8] <= data_byte_in;
            end
            if (r_byteIdx == LAST_LANE) begin
              r_byteIdx <= '0;
              r_wordCnt <= r_wordCnt + 8'd1;
            end else begin
              r_byteIdx <= r_byteIdx + LW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_FRAME_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frames_ok_count_out  <= 16'd0;
      frames_err_count_out <= 16'd0;
    end else begin
      if (frame_ok_out && (frames_ok_count_out != 16'hFFFF))
        frames_ok_count_out <= frames_ok_count_out + 16'd1;
      if (frame_err_out && (frames_err_count_out != 16'hFFFF))
        frames_err_count_out <= frames_err_count_out + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: table of whole frames plus timeout, overrun and reset sequences.
module tb_uart_frame_decoder;

   localparam int WB = 4;
   localparam int TO = 100;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic [7:0]        data_byte_in;
   logic              new_data_in;
   logic [8*WB-1:0]   word_out;
   logic              word_valid_out;
   logic              word_ready_in;
   logic              word_last_out;
   logic [7:0]        cmd_out;
   logic              frame_start_out;
   logic              frame_ok_out;
   logic              frame_err_out;
   logic [1:0]        err_code_out;
`ifdef UART_FRAME_STATS_EN
   logic [15:0]       frames_ok_count_out;
   logic [15:0]       frames_err_count_out;
`endif

   always #5 clk_in = ~clk_in;

   uart_frame_decoder #(
      .SYNC_BYTE(8'hA5),
      .WORD_BYTES(WB),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .data_byte_in(data_byte_in),
      .new_data_in(new_data_in),
      .word_out(word_out),
      .word_valid_out(word_valid_out),
      .word_ready_in(word_ready_in),
      .word_last_out(word_last_out),
      .cmd_out(cmd_out),
      .frame_start_out(frame_start_out),
      .frame_ok_out(frame_ok_out),
      .frame_err_out(frame_err_out),
      .err_code_out(err_code_out)
`ifdef UART_FRAME_STATS_EN
      ,
      .frames_ok_count_out(frames_ok_count_out),
      .frames_err_count_out(frames_err_count_out)
`endif
   );

   // Each frame is stored left-justified: byte 0 lives in bits [95:88].
   typedef struct {
      string       name;
      int          nBytes;
      logic [95:0] bytes;
      int          expWords;
      logic [31:0] w0;
      logic [31:0] w1;
      int          expOk;
      int          expErr;
      logic [1:0]  code;
      logic [7:0]  cmd;
   } vec_t;

   vec_t        tbl [6];
   logic [31:0] wordLog [0:63];
   logic        lastLog [0:63];
   int          wordN  = 0;
   int          startN = 0;
   int          okN    = 0;
   int          errN   = 0;
   logic [1:0]  lastCode = 2'd0;
   int          nChecks = 0;
   int          nFails  = 0;

   // Outputs are observed on the falling edge; a word seen valid&&ready here is taken on the next rising edge.
   always @(negedge clk_in) begin
      if (word_valid_out && word_ready_in && wordN < 64) begin
         wordLog[wordN] = word_out;
         lastLog[wordN] = word_last_out;
         wordN++;
      end
      if (frame_start_out) startN++;
      if (frame_ok_out) okN++;
      if (frame_err_out) begin
         errN++;
         lastCode = err_code_out;
      end
   end

   // Safety net so the run can never hang.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [95:0] bytes, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in); #2;
         data_byte_in = bytes[95-8*i -: 8];
         new_data_in  = 1'b1;
         @(posedge clk_in); #2;
         new_data_in  = 1'b0;
      end
   endtask

   initial begin
      int s0w, s0s, s0o, s0e;

      tbl[0] = '{"good1",   8, 96'hA501_0111_2233_4444_0000_0000, 1, 32'h44332211, 32'h0,        1, 0, 2'd0, 8'h01};
      tbl[1] = '{"badchk",  8, 96'hA501_0111_2233_4445_0000_0000, 1, 32'h44332211, 32'h0,        0, 1, 2'd1, 8'h01};
      tbl[2] = '{"len0ok",  4, 96'hA507_0007_0000_0000_0000_0000, 0, 32'h0,        32'h0,        1, 0, 2'd0, 8'h07};
      tbl[3] = '{"len0bad", 4, 96'hA507_0006_0000_0000_0000_0000, 0, 32'h0,        32'h0,        0, 1, 2'd1, 8'h07};
      tbl[4] = '{"noise",  10, 96'h00FF_A5A5_01A5_A5A5_A5A4_0000, 1, 32'hA5A5A5A5, 32'h0,        1, 0, 2'd0, 8'hA5};
      tbl[5] = '{"twoword",12, 96'hA503_0201_0203_0405_0607_0809, 2, 32'h04030201, 32'h08070605, 1, 0, 2'd0, 8'h03};

      rst_n_in      = 1'b0;
      data_byte_in  = 8'h00;
      new_data_in   = 1'b0;
      word_ready_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #3;
      checkOutput("reset word_valid", 32'(word_valid_out), 32'd0);
      checkOutput("reset word_out",   32'(word_out),       32'd0);
      checkOutput("reset cmd_out",    32'(cmd_out),        32'd0);
      checkOutput("reset pulses",     32'({frame_start_out, frame_ok_out, frame_err_out, err_code_out}), 32'd0);
      rst_n_in = 1'b1;
      repeat (2) @(posedge clk_in);

      $display("[TB] table-driven frames");
      for (int r = 0; r < 6; r++) begin
         s0w = wordN; s0s = startN; s0o = okN; s0e = errN;
         applyStimulus(tbl[r].bytes, tbl[r].nBytes);
         repeat (4) @(posedge clk_in);
         #3;
         checkOutput({tbl[r].name, " words"}, 32'(wordN - s0w),  32'(tbl[r].expWords));
         checkOutput({tbl[r].name, " start"}, 32'(startN - s0s), 32'd1);
         checkOutput({tbl[r].name, " ok"},    32'(okN - s0o),    32'(tbl[r].expOk));
         checkOutput({tbl[r].name, " err"},   32'(errN - s0e),   32'(tbl[r].expErr));
         checkOutput({tbl[r].name, " cmd"},   32'(cmd_out),      32'(tbl[r].cmd));
         if (tbl[r].expErr > 0) checkOutput({tbl[r].name, " code"}, 32'(lastCode), 32'(tbl[r].code));
         if (tbl[r].expWords >= 1 && wordN > s0w) begin
            checkOutput({tbl[r].name, " word0"}, wordLog[s0w], tbl[r].w0);
            checkOutput({tbl[r].name, " last0"}, 32'(lastLog[s0w]), 32'(tbl[r].expWords == 1));
         end
         if (tbl[r].expWords >= 2 && wordN > s0w + 1) begin
            checkOutput({tbl[r].name, " word1"}, wordLog[s0w+1], tbl[r].w1);
            checkOutput({tbl[r].name, " last1"}, 32'(lastLog[s0w+1]), 32'd1);
         end
      end

      $display("[TB] timeout sequence");
      s0e = errN; s0o = okN;
      applyStimulus(96'hA502_0000_0000_0000_0000_0000, 2);
      repeat (90) @(posedge clk_in);
      #3;
      checkOutput("timeout early err", 32'(errN - s0e), 32'd0);
      for (int c = 0; c < 60 && errN == s0e; c++) @(posedge clk_in);
      repeat (150) @(posedge clk_in);
      #3;
      checkOutput("timeout err count", 32'(errN - s0e), 32'd1);
      checkOutput("timeout code",      32'(lastCode),   32'd3);
      checkOutput("timeout no ok",     32'(okN - s0o),  32'd0);
      s0w = wordN; s0o = okN;
      applyStimulus(tbl[0].bytes, tbl[0].nBytes);
      repeat (4) @(posedge clk_in);
      #3;
      checkOutput("post-timeout ok", 32'(okN - s0o), 32'd1);
      if (wordN > s0w) checkOutput("post-timeout word", wordLog[s0w], 32'h44332211);
      else             checkOutput("post-timeout word count", 32'(wordN - s0w), 32'd1);

      $display("[TB] overrun sequence");
      word_ready_in = 1'b0;
      s0w = wordN; s0o = okN; s0e = errN;
      applyStimulus(tbl[5].bytes, tbl[5].nBytes);
      repeat (4) @(posedge clk_in);
      #3;
      checkOutput("overrun err",        32'(errN - s0e),     32'd1);
      checkOutput("overrun code",       32'(lastCode),       32'd2);
      checkOutput("overrun no ok",      32'(okN - s0o),      32'd0);
      checkOutput("overrun held valid", 32'(word_valid_out), 32'd1);
      checkOutput("overrun held word",  word_out,            32'h04030201);
      checkOutput("overrun held last",  32'(word_last_out),  32'd0);
      word_ready_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #3;
      checkOutput("overrun drained count", 32'(wordN - s0w),   32'd1);
      checkOutput("overrun drained valid", 32'(word_valid_out), 32'd0);
      if (wordN > s0w) checkOutput("overrun drained word", wordLog[s0w], 32'h04030201);

      $display("[TB] mid-frame reset sequence");
      word_ready_in = 1'b0;
      applyStimulus(tbl[0].bytes, tbl[0].nBytes);
      applyStimulus(96'hA501_0111_2200_0000_0000_0000, 5);
      @(posedge clk_in); #3;
      checkOutput("pre-reset valid", 32'(word_valid_out), 32'd1);
      s0w = wordN; s0s = startN; s0o = okN; s0e = errN;
      rst_n_in = 1'b0;
      #1;
      checkOutput("async reset valid", 32'(word_valid_out), 32'd0);
      checkOutput("async reset word",  32'(word_out),       32'd0);
      checkOutput("async reset cmd",   32'(cmd_out),        32'd0);
      @(posedge clk_in); #4;
      rst_n_in      = 1'b1;
      word_ready_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #3;
      checkOutput("reset no spurious", 32'((wordN - s0w) + (startN - s0s) + (okN - s0o) + (errN - s0e)), 32'd0);
      s0w = wordN; s0o = okN; s0e = errN;
      applyStimulus(tbl[5].bytes, tbl[5].nBytes);
      repeat (4) @(posedge clk_in);
      #3;
      checkOutput("post-reset words", 32'(wordN - s0w), 32'd2);
      checkOutput("post-reset ok",    32'(okN - s0o),   32'd1);
      checkOutput("post-reset err",   32'(errN - s0e),  32'd0);
      if (wordN > s0w + 1) begin
         checkOutput("post-reset word0", wordLog[s0w],   32'h04030201);
         checkOutput("post-reset word1", wordLog[s0w+1], 32'h08070605);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
